// File: rtl/cnn1d_pkg.sv
// rtl/cnn1d_pkg.sv - shared constants, types and helpers for the 1D CNN datapath
package cnn1d_pkg;

  localparam int DATA_WIDTH          = 12;
  localparam int FRACTION            = 6;
  localparam int SUPPORTED_PRECISION = 10;
  localparam int LPM_PIPE_WIDTH      = 4;
  localparam int MULT_LATENCY        = LPM_PIPE_WIDTH;
  localparam int EXP_ONE             = 1 << FRACTION;

  typedef enum logic [2:0] {
    EXP_IDLE  = 3'd0,
    EXP_MUL_X = 3'd1,
    EXP_MUL_R = 3'd2,
    EXP_ADD   = 3'd3,
    EXP_DONE  = 3'd4
  } exp_state_t;

  // round(2^frac / n), i.e. the Taylor coefficient 1/n in fixed point
  function automatic int exp_recip(input int n, input int frac);
    return ((1 << frac) + n / 2) / n;
  endfunction

  // Clamp a sign-extended value into a dw-bit two's complement range
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v,
                                                input int dw,
                                                output logic ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    ovf = 1'b0;
    if (v > hi) begin
      ovf = 1'b1;
      return hi;
    end
    if (v < lo) begin
      ovf = 1'b1;
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/cnn1d_fxp_mult.sv
// rtl/cnn1d_fxp_mult.sv - pipelined signed fixed-point multiplier with shift and saturation
module cnn1d_fxp_mult
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH   = cnn1d_pkg::DATA_WIDTH,
  parameter int FRACTION     = cnn1d_pkg::FRACTION,
  parameter int MULT_LATENCY = cnn1d_pkg::MULT_LATENCY
) (
  input  logic                         clk,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] p_o,
  output logic                         ovf_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] pipe_q [MULT_LATENCY];
  logic signed [63:0]   wide_w;
  logic signed [63:0]   shr_w;
  logic signed [63:0]   sat_w;

  always_ff @(posedge clk) begin
    pipe_q[0] <= PW'(a_i) * PW'(b_i);
    for (int i = 1; i < MULT_LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Arithmetic shift truncates toward -inf before the range check
  always_comb begin
    wide_w = 64'(pipe_q[MULT_LATENCY-1]);
    shr_w  = wide_w >>> FRACTION;
    sat_w  = sat_dw(shr_w, DATA_WIDTH, ovf_o);
    p_o    = DATA_WIDTH'(sat_w);
  end

endmodule

// File: rtl/cnn1d_exp.sv
// rtl/cnn1d_exp.sv - iterative Horner-form Taylor e^x unit for the softmax stage
module cnn1d_exp
  import cnn1d_pkg::*;
#(
  parameter int DATA_WIDTH   = cnn1d_pkg::DATA_WIDTH,
  parameter int FRACTION     = cnn1d_pkg::FRACTION,
  parameter int PRECISION    = cnn1d_pkg::SUPPORTED_PRECISION,
  parameter int MULT_LATENCY = cnn1d_pkg::MULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_overflow
);

  localparam int NW = $clog2(PRECISION + 1);
  localparam int CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam logic signed [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1 << FRACTION);

  if (PRECISION < 1 || PRECISION > SUPPORTED_PRECISION) begin : g_bad_precision
    $error("cnn1d_exp: PRECISION must be within 1..SUPPORTED_PRECISION");
  end

  logic signed [DATA_WIDTH-1:0] recip_w [PRECISION+1];
  assign recip_w[0] = '0;
  for (genvar i = 1; i <= PRECISION; i++) begin : g_recip
    assign recip_w[i] = DATA_WIDTH'(exp_recip(i, FRACTION));
  end

  exp_state_t                   state_q, state_d;
  logic signed [DATA_WIDTH-1:0] x_q, x_d;
  logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [NW-1:0]                n_q, n_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;

  logic signed [DATA_WIDTH-1:0] mul_a, mul_b, mul_p;
  logic                         mul_ovf;
  logic signed [63:0]           sum_w, sum_sat_w;
  logic signed [DATA_WIDTH-1:0] acc_sum;
  logic                         add_ovf;

  cnn1d_fxp_mult #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACTION    (FRACTION),
    .MULT_LATENCY(MULT_LATENCY)
  ) u_mult (
    .clk  (clk),
    .a_i  (mul_a),
    .b_i  (mul_b),
    .p_o  (mul_p),
    .ovf_o(mul_ovf)
  );

  // The multiplier output is p on the first MUL_R cycle and q during ADD
  always_comb begin
    mul_a     = (state_q == EXP_MUL_X) ? acc_q : mul_p;
    mul_b     = (state_q == EXP_MUL_X) ? x_q : recip_w[n_q];
    sum_w     = 64'(mul_p) + 64'(ONE);
    sum_sat_w = sat_dw(sum_w, DATA_WIDTH, add_ovf);
    acc_sum   = DATA_WIDTH'(sum_sat_w);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    acc_d      = acc_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    case (state_q)
      EXP_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          acc_d   = ONE;
          n_d     = NW'(PRECISION);
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = EXP_MUL_X;
        end
      end
      EXP_MUL_X, EXP_MUL_R: begin
        if (state_q == EXP_MUL_R && cnt_q == '0 && mul_ovf) ovf_d = 1'b1;
        if (cnt_q == CW'(MULT_LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == EXP_MUL_X) ? EXP_MUL_R : EXP_ADD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      EXP_ADD: begin
        acc_d = acc_sum;
        ovf_d = ovf_q | mul_ovf | add_ovf;
        if (n_q == NW'(1)) begin
          out_data_d = acc_sum[DATA_WIDTH-1] ? '0 : acc_sum;
          state_d    = EXP_DONE;
        end else begin
          n_d     = n_q - NW'(1);
          state_d = EXP_MUL_X;
        end
      end
      EXP_DONE: begin
        if (out_ready) state_d = EXP_IDLE;
      end
      default: state_d = EXP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EXP_IDLE;
      x_q        <= '0;
      acc_q      <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready     = (state_q == EXP_IDLE) && !rst;
  assign out_valid    = (state_q == EXP_DONE);
  assign out_data     = out_data_q;
  assign out_overflow = ovf_q;

endmodule
